// File: rtl/fruta_spawner.sv
// Fruit spawner: draws LFSR candidates, probes the map through its read port and
// writes CELL_FRUIT into the first empty in-range cell, giving up after MAX_TRIES.
module fruta_spawner #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MAX_TRIES   = 64,
  parameter logic [3:0]  CELL_EMPTY  = 4'd0,
  parameter logic [3:0]  CELL_FRUIT  = 4'd2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spawn_req_i,
  output logic       spawn_busy_o,
  output logic       spawn_done_o,
  output logic       spawn_fail_o,
  output logic       map_renable_o,
  output logic [9:0] map_rx_o,
  output logic [9:0] map_ry_o,
  input  logic [3:0] map_rdata_i,
  output logic       map_wenable_o,
  output logic [9:0] map_wx_o,
  output logic [9:0] map_wy_o,
  output logic [3:0] map_wdata_o,
  output logic [9:0] fruit_x_o,
  output logic [9:0] fruit_y_o
);

  localparam int          TRIES_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PICK  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAIL  = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [9:0]         cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic               ren_q, ren_d, wen_q, wen_d;
  logic [9:0]         rx_q, rx_d, ry_q, ry_d, wx_q, wx_d, wy_q, wy_d;
  logic [3:0]         wdata_q, wdata_d;
  logic [9:0]         fx_q, fx_d, fy_q, fy_d;

  logic [9:0] cand_x, cand_y;
  logic       in_range, reject;

  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand_x   = {4'd0, lfsr_q[5:0]};
  assign cand_y   = {5'd0, lfsr_q[11:7]};
  assign in_range = (cand_x < 10'(MAPA_WIDTH)) && (cand_y < 10'(MAPA_HEIGHT));

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    ren_d    = 1'b0;
    wen_d    = 1'b0;
    rx_d     = rx_q;
    ry_d     = ry_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    wdata_d  = wdata_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    reject   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spawn_req_i) begin
          state_d = S_PICK;
          tries_d = '0;
          busy_d  = 1'b1;
        end
      end
      S_PICK: begin
        cand_x_d = cand_x;
        cand_y_d = cand_y;
        if (in_range) begin
          state_d = S_READ;
          ren_d   = 1'b1;
          rx_d    = cand_x;
          ry_d    = cand_y;
        end else begin
          reject = 1'b1;
        end
      end
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (map_rdata_i == CELL_EMPTY) begin
          state_d = S_WRITE;
          wen_d   = 1'b1;
          wx_d    = cand_x_q;
          wy_d    = cand_y_q;
          wdata_d = CELL_FRUIT;
        end else begin
          reject = 1'b1;
        end
      end
      S_WRITE: begin
        fx_d    = cand_x_q;
        fy_d    = cand_y_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE, S_FAIL: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Shared retry bookkeeping for both out-of-range and occupied candidates
    if (reject) begin
      if (tries_q == LAST_TRY) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end else begin
        tries_d = tries_q + TRIES_W'(1);
        state_d = S_PICK;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_INIT;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      wdata_q  <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      wdata_q  <= wdata_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
    end
  end

  assign spawn_busy_o  = busy_q;
  assign spawn_done_o  = done_q;
  assign spawn_fail_o  = fail_q;
  assign map_renable_o = ren_q;
  assign map_rx_o      = rx_q;
  assign map_ry_o      = ry_q;
  assign map_wenable_o = wen_q;
  assign map_wx_o      = wx_q;
  assign map_wy_o      = wy_q;
  assign map_wdata_o   = wdata_q;
  assign fruit_x_o     = fx_q;
  assign fruit_y_o     = fy_q;

endmodule

// File: tb/tb_fruta_spawner.sv
// Randomised scoreboard bench for fruta_spawner: a map model answers reads, a
// spec-level predictor queues each spawn's outcome and a monitor checks it.
module tb_fruta_spawner;
  localparam int W = 40;
  localparam int H = 30;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    bit fail;
    int x;
    int y;
    int reads;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spawn_req = 1'b0;
  logic spawn_busy, spawn_done, spawn_fail, ren, wen;
  logic [9:0] rx, ry, wx, wy, fruit_x, fruit_y;
  logic [3:0] rdata = 4'd0;
  logic [3:0] wdata;

  logic req2 = 1'b0;
  logic busy2, done2, fail2, ren2, wen2;
  logic [9:0] rx2, ry2, wx2, wy2, fx2, fy2;
  logic [3:0] wdata2;
  logic [3:0] rdata2;
  assign rdata2 = 4'd1;

  logic [3:0] mem  [0:63][0:31];
  logic [3:0] pmap [0:63][0:31];
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  fruta_spawner u_dut (
    .clk_i(clk), .rst_ni(rst_n), .spawn_req_i(spawn_req),
    .spawn_busy_o(spawn_busy), .spawn_done_o(spawn_done), .spawn_fail_o(spawn_fail),
    .map_renable_o(ren), .map_rx_o(rx), .map_ry_o(ry), .map_rdata_i(rdata),
    .map_wenable_o(wen), .map_wx_o(wx), .map_wy_o(wy), .map_wdata_o(wdata),
    .fruit_x_o(fruit_x), .fruit_y_o(fruit_y));

  fruta_spawner #(.MAX_TRIES(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .spawn_req_i(req2),
    .spawn_busy_o(busy2), .spawn_done_o(done2), .spawn_fail_o(fail2),
    .map_renable_o(ren2), .map_rx_o(rx2), .map_ry_o(ry2), .map_rdata_i(rdata2),
    .map_wenable_o(wen2), .map_wx_o(wx2), .map_wy_o(wy2), .map_wdata_o(wdata2),
    .fruit_x_o(fx2), .fruit_y_o(fy2));

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR value and cycle index since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      cyc    <= 0;
    end else begin
      m_lfsr <= step(m_lfsr);
      cyc    <= cyc + 1;
    end
  end

  always @(posedge clk) if (ren) rdata <= mem[rx[5:0]][ry[4:0]];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of a request seen by the DUT during cycle n, with LFSR value lreq then
  task automatic predict(input int n, input logic [15:0] lreq, input int maxt,
                         input bit full, output exp_t e);
    logic [15:0] l;
    int p, x, y;
    l = step(lreq);
    p = n + 1;
    e.fail = 1'b1; e.x = 0; e.y = 0; e.reads = 0; e.cyc = 0;
    for (int t = 0; t < maxt; t++) begin
      x = int'(l[5:0]);
      y = int'(l[11:7]);
      if (x < W && y < H) begin
        e.reads = e.reads + 1;
        if (!full && pmap[x][y] == 4'd0) begin
          e.fail = 1'b0; e.x = x; e.y = y; e.cyc = p + 4;
          return;
        end
        e.cyc = p + 3;
        l = step(step(step(l)));
        p = p + 3;
      end else begin
        e.cyc = p + 1;
        l = step(l);
        p = p + 1;
      end
    end
  endtask

  task automatic push_exp(input exp_t e);
    q.push_back(e);
    if (!e.fail) pmap[e.x][e.y] = 4'd2;
  endtask

  // Called at a negedge while the DUT is idle
  task automatic pulse_req(output exp_t e, output int n);
    n = cyc;
    predict(n, m_lfsr, 64, 1'b0, e);
    push_exp(e);
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("spawn_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++) begin
        mem[i][j] = 4'd0;
        pmap[i][j] = 4'd0;
      end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an outcome
  initial begin : monitor
    int reads_seen = 0, writes_seen = 0, tr = 0;
    bit after = 1'b0;
    int fx_exp = 0, fy_exp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reads_seen = 0; writes_seen = 0; after = 1'b0; fx_exp = 0; fy_exp = 0;
        continue;
      end
      if (after) begin
        chk("busy_after_end", spawn_busy, 0);
        after = 1'b0;
      end
      if (ren && wen) chk("read_write_overlap", 1, 0);
      if (ren) begin
        chk("read_while_pending", q.size() != 0, 1);
        reads_seen++;
      end
      if (wen) begin
        chk("write_while_pending", q.size() != 0, 1);
        writes_seen++;
        if (q.size() != 0) begin
          chk("write_x", wx, q[0].x);
          chk("write_y", wy, q[0].y);
          chk("write_cycle", cyc, q[0].cyc - 1);
          chk("write_is_expected", q[0].fail, 0);
        end
        chk("write_data", wdata, 2);
        chk("write_target_empty", mem[wx[5:0]][wy[4:0]], 0);
        mem[wx[5:0]][wy[4:0]] = wdata;
      end
      if (spawn_done || spawn_fail) begin
        chk("outcome_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          tr++;
          chk("outcome_kind", spawn_fail, e.fail);
          chk("outcome_cycle", cyc, e.cyc);
          chk("read_count", reads_seen, e.reads);
          chk("write_count", writes_seen, e.fail ? 0 : 1);
          chk("busy_at_end", spawn_busy, 1);
          if (!e.fail) begin
            fx_exp = e.x;
            fy_exp = e.y;
          end
          chk("fruit_x", fruit_x, fx_exp);
          chk("fruit_y", fruit_y, fy_exp);
          $display("spawn %0d: %s x=%0d y=%0d reads=%0d cycle=%0d", tr,
                   e.fail ? "gave up" : "placed", fruit_x, fruit_y, reads_seen, cyc);
        end
        reads_seen = 0;
        writes_seen = 0;
        after = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int n, k, r, w, d;
    bit got;
    logic [15:0] l;
    int x, y;

    clear_map();
    repeat (3) @(negedge clk);
    chk("rst_busy", spawn_busy, 0);
    chk("rst_done_fail", {spawn_done, spawn_fail}, 0);
    chk("rst_strobes", {ren, wen}, 0);
    chk("rst_raddr", {rx, ry}, 0);
    chk("rst_waddr", {wx, wy, wdata}, 0);
    chk("rst_fruit", {fruit_x, fruit_y}, 0);
    rst_n = 1'b1;

    // Empty map
    @(negedge clk);
    pulse_req(e, n);
    wait_idle(3 * 64 + 10);

    // Occupied map, four tries
    @(negedge clk);
    predict(cyc, m_lfsr, 4, 1'b1, e);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    r = 0; w = 0; d = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (ren2) r++;
      if (wen2) w++;
      if (done2) d++;
      if (fail2) begin
        got = 1'b1;
        chk("full_fail_cycle", cyc, e.cyc);
      end
    end
    chk("full_fail_seen", got, 1);
    chk("full_reads", r, e.reads);
    chk("full_writes", w, 0);
    chk("full_done", d, 0);
    chk("full_fruit", {fx2, fy2}, 0);
    @(negedge clk);
    chk("full_busy_after", busy2, 0);

    // First probed cell occupied, second empty
    clear_map();
    @(negedge clk);
    l = step(m_lfsr);
    x = int'(l[5:0]); y = int'(l[11:7]);
    while (!(x < W && y < H)) begin
      l = step(l);
      x = int'(l[5:0]); y = int'(l[11:7]);
    end
    mem[x][y] = 4'd3;
    pmap[x][y] = 4'd3;
    pulse_req(e, n);
    chk("two_probe_plan", e.reads, 2);
    wait_idle(3 * 64 + 10);

    // Request held for 20 cycles
    @(negedge clk);
    n = cyc;
    l = m_lfsr;
    k = n;
    while (k <= n + 19) begin
      predict(k, l, 64, 1'b0, e);
      push_exp(e);
      for (int i = k; i < e.cyc + 1; i++) l = step(l);
      k = e.cyc + 1;
    end
    spawn_req = 1'b1;
    repeat (20) @(negedge clk);
    spawn_req = 1'b0;
    wait_idle(3 * 64 + 10);

    // Reset while a read is in flight
    @(negedge clk);
    pulse_req(e, n);
    got = 1'b0;
    for (int i = 0; i < 3 * 64 + 10 && !got; i++) begin
      if (ren) got = 1'b1;
      else @(negedge clk);
    end
    chk("read_before_reset", got, 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_busy", spawn_busy, 0);
    chk("arst_strobes", {ren, wen, spawn_done, spawn_fail}, 0);
    chk("arst_addr", {rx, ry, wx, wy, wdata}, 0);
    chk("arst_fruit", {fruit_x, fruit_y}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++) pmap[i][j] = mem[i][j];
    w = 0;
    repeat (10) begin
      @(negedge clk);
      if (wen || ren) w++;
    end
    chk("quiet_after_reset", w, 0);
    pulse_req(e, n);
    wait_idle(3 * 64 + 10);

    // Random map, 100 spawns with stray requests while busy
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++) begin
        mem[i][j] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
        pmap[i][j] = mem[i][j];
      end
    for (int s = 0; s < 100; s++) begin
      wait_idle(3 * 64 + 10);
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_req(e, n);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, e.cyc - n - 1);
        repeat (k) @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
      end
    end
    wait_idle(3 * 64 + 10);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
